// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: shared state encoding, range thresholds and gate-period helper for the frequency counter
package freq_counter_pkg;
  localparam logic [1:0] ST_LOAD = 2'd0, ST_SETTLE = 2'd1, ST_MEASURE = 2'd2, ST_DECIDE = 2'd3;
  typedef enum logic [1:0] {
    LOAD    = ST_LOAD,
    SETTLE  = ST_SETTLE,
    MEASURE = ST_MEASURE,
    DECIDE  = ST_DECIDE
  } state_t;
  localparam int NUM_RANGES = 3;
  localparam int COUNT_HIGH = 100;
  localparam int COUNT_LOW = 10;
  function automatic int range_period(int base, int r);
    int p = base + 1;
    for (int i = 0; i < r; i++) p = p / 10;
    return p - 1;
  endfunction
endpackage

// File: rtl/frequency_autorange_ctrl_if.sv
// frequency_autorange_ctrl_if: result/manual inputs and period/range outputs of the autorange controller
interface frequency_autorange_ctrl_if #(parameter int BITS = 12);
  logic            result_valid;
  logic [6:0]      result_count;
  logic            manual_en;
  logic [1:0]      manual_range;
  logic [BITS-1:0] period;
  logic            period_load;
  logic [1:0]      range;
  logic            settling;
  modport master (
    output result_valid, result_count, manual_en, manual_range,
    input  period, period_load, range, settling
  );
  modport slave (
    input  result_valid, result_count, manual_en, manual_range,
    output period, period_load, range, settling
  );
endinterface

// File: rtl/frequency_autorange_ctrl.sv
// frequency_autorange_ctrl: picks one of three decade gate periods from completed window counts.
// Define AUTORANGE_HOLD_EN to require HOLD_WINDOWS consecutive low counts before stepping down.
module frequency_autorange_ctrl
  import freq_counter_pkg::*;
#(
  parameter int BITS = 12,
  parameter int BASE_PERIOD = 1199,
  parameter int HOLD_WINDOWS = 3
) (
  input logic clk,
  input logic reset,
  frequency_autorange_ctrl_if.slave bus
);
  localparam logic [1:0] TOP = 2'(NUM_RANGES - 1);
  localparam logic [BITS-1:0] P0 = BITS'(range_period(BASE_PERIOD, 0));
  localparam logic [BITS-1:0] P1 = BITS'(range_period(BASE_PERIOD, 1));
  localparam logic [BITS-1:0] P2 = BITS'(range_period(BASE_PERIOD, 2));
  state_t state_q, state_d;
  logic [1:0] range_q, range_d, man_range;
  logic [6:0] count_q;
  logic step_up, step_down, hold_done;
  assign man_range = bus.manual_range == 2'd3 ? TOP : bus.manual_range;
  assign step_up = count_q >= 7'(COUNT_HIGH) && range_q != TOP;
  assign step_down = count_q < 7'(COUNT_LOW) && range_q != 2'd0 && hold_done;
  always_ff @(posedge clk) begin
    state_q <= reset ? LOAD : state_d;
    range_q <= reset ? 2'd0 : range_d;
    if (state_q == MEASURE && bus.result_valid) count_q <= bus.result_count;
  end
  always_comb begin
    state_d = state_q;
    range_d = range_q;
    case (state_q)
      LOAD:    state_d = SETTLE;
      SETTLE:  state_d = bus.result_valid ? MEASURE : SETTLE;
      MEASURE: begin
        range_d = bus.manual_en ? man_range : range_q;
        state_d = range_d != range_q ? LOAD : bus.result_valid ? DECIDE : MEASURE;
      end
      DECIDE:  begin
        range_d = bus.manual_en ? man_range :
                  step_up       ? range_q + 2'd1 :
                  step_down     ? range_q - 2'd1 : range_q;
        state_d = range_d != range_q ? LOAD : MEASURE;
      end
    endcase
  end
`ifdef AUTORANGE_HOLD_EN
  localparam int HW = $clog2(HOLD_WINDOWS + 1);
  logic [HW-1:0] hold_q;
  assign hold_done = hold_q == HW'(HOLD_WINDOWS - 1);
  // only low counts seen at a range that can still step down accumulate
  always_ff @(posedge clk)
    if (reset || bus.manual_en || range_d != range_q) hold_q <= '0;
    else if (state_q == DECIDE) hold_q <= count_q < 7'(COUNT_LOW) && range_q != 2'd0 ? hold_q + 1'b1 : '0;
`else
  localparam int unused_hold_windows = HOLD_WINDOWS;
  assign hold_done = 1'b1;
`endif
  assign bus.period = range_q == 2'd0 ? P0 : range_q == 2'd1 ? P1 : P2;
  assign bus.period_load = state_q == LOAD && !reset;
  assign bus.range = range_q;
  assign bus.settling = state_q == SETTLE;
endmodule
